mmu_pager: RTL
==============

// Module: mmu_pager
// PURPOSE
// Parametrised multi-task paging MMU for the 6809 board CPLD. Maps CPU ADDR
// to PADDR through an internal page table of TASKS contexts. Adds per-page
// write protect with fault capture and IRQ, plus a delayed task switch so an
// RTI completes in the old map. Vector fetch forces task 0.
// PARAMETERS
// PAGE_BITS    3        top ADDR bits used as page index (8 x 8K pages)
// TASKS        4        number of contexts, power of 2, 2..16
// PHYS_BITS    21       PADDR width; FRAME_W = PHYS_BITS-(16-PAGE_BITS), max 8
// MMU_BASE     16'hFE20 base of 8-byte register block
// IO_ADDR_MIN  16'hFC00 identity-mapped, never protected, window start
// IO_ADDR_MAX  16'hFEFF identity window end
// SWITCH_DELAY 3        E cycles between TASK write and switch; 0 = next cycle
// PORTS
// CLKX4      in  1         system clock (4x E)
// RESET      in  1         synchronous, active-high
// E          in  1         CPU E, asynchronous; synchronised internally
// ADDR       in  16        CPU address
// BA, BS     in  1         CPU bus status; BS=1,BA=0 = vector fetch
// RnW        in  1         CPU read/not-write
// DATA_in    in  8         CPU data in
// DATA_out   out 8         register read data
// DATA_oe    out 1         drive DATA: RnW & E & register hit
// PADDR      out PHYS_BITS translated address, registered
// WR_INHIBIT out 1         high: suppress nWR (protected write)
// FAULT      out 1         sticky write-protect fault
// nIRQ       out 1         low while FAULT & CTRL.IRQEN
// BEHAVIOUR
// - E: 2-flop sync, edge detect -> e_fall pulse (1 CLKX4). All state commits
//   (register writes, switch countdown, fault latch, task force) on e_fall only.
// - Regs (offset): 0 TASK w: pending task; r: {pend,000,cur}. 1 INDEX {task,page},
//   auto-inc on access to 2 or 3, wraps to 0. 2 FRAME. 3 FLAGS bit0 WP.
//   4 STATUS bit0 FAULT, bit7 pending; write 1 to bit0 clears. 5 CTRL bit0 EN,
//   bit1 VEC, bit2 IRQEN. 6 FAULTINFO {task,page} latched. 7 reserved: reads 0.
// - Translation: eff_task = (VEC & BS & ~BA) ? 0 : cur_task.
//   EN=0 or ADDR in IO window -> PADDR = zero-extended ADDR.
//   else PADDR = {frame[eff_task][page], ADDR[15-PAGE_BITS:0]}.
//   PADDR registered each CLKX4: valid 1 CLKX4 after ADDR stable.
// - Protect: EN & ~RnW & WP[eff_task][page] & not IO -> WR_INHIBIT comb high.
//   At e_fall: FAULT=1, FAULTINFO captured; later faults do not overwrite.
//   Register block never inhibited.
// - Task switch FSM: IDLE -> (TASK write) COUNT (cnt=SWITCH_DELAY) -> per e_fall
//   cnt-1; at 0 cur_task=pending -> IDLE. DELAY=0: switch at that same e_fall.
//   TASK write in COUNT restarts with new value. Vector fetch at e_fall:
//   cur_task=0, pending cancelled -> IDLE (vector wins).
// - Reset: cur_task=0, IDLE, CTRL=0, FAULT=0, FAULTINFO=0, INDEX=0,
//   frame[t][p]=p, WP=0; DATA_oe=0, WR_INHIBIT=0, nIRQ=1, PADDR=0.
// - RESET mid-countdown discards pending switch. E stuck: no state change.
// - Index/frame widths truncate on write; unused read bits return 0.
// STRUCTURE
// - mmu_defs.vh: register offsets, CTRL/STATUS bit positions, FSM encodings.
// - Sub-module mmu_esync: E synchroniser + e_rise/e_fall pulses.
// - Page table: TASKS*2^PAGE_BITS flop entries {WP, frame}, reset to identity.
// TESTING
// - Reset, EN=0, ADDR=C123 -> PADDR=0C123; read CTRL -> 00, nIRQ=1.
// - INDEX=0A, FRAME=42, CTRL=01, TASK=1, DELAY=3: ADDR=4010 maps 0x04010
//   for 3 more E cycles, then 0x84010; STATUS bit7 clears at switch.
// - WP task0 page7, EN=1, write E000 -> WR_INHIBIT=1, FAULT=1, FAULTINFO=07;
//   write 01 to STATUS -> FAULT=0; IRQEN=1 toggles nIRQ accordingly.
// - Pending switch + vector fetch (BS=1,BA=0, FFFE) -> task 0 used, pending
//   cancelled, no later switch; write FE10 never inhibited.
// - INDEX=1F, write FRAME twice -> entries 1F then 00; RESET mid-count -> task 0.

Source files
------------

// File: rtl/mmu_pager_pkg.sv
// mmu_pager_pkg: shared definitions for the paging MMU.
//   - register offsets inside the 8-byte register block
//   - CTRL / STATUS bit positions
//   - task switch FSM state encoding
//   - address window helper
package mmu_pager_pkg;

    localparam logic [2:0] OFF_TASK   = 3'd0;
    localparam logic [2:0] OFF_INDEX  = 3'd1;
    localparam logic [2:0] OFF_FRAME  = 3'd2;
    localparam logic [2:0] OFF_FLAGS  = 3'd3;
    localparam logic [2:0] OFF_STATUS = 3'd4;
    localparam logic [2:0] OFF_CTRL   = 3'd5;
    localparam logic [2:0] OFF_FINFO  = 3'd6;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_VEC     = 1;
    localparam int CTRL_IRQEN   = 2;
    localparam int STATUS_FAULT = 0;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } sw_state_t;

    function automatic logic in_window(input logic [15:0] a,
                                       input logic [15:0] lo,
                                       input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/mmu_pager_esync.sv
// mmu_pager_esync: brings the asynchronous CPU E clock into the CLKX4
// domain with a two-flop synchroniser and produces a one-cycle pulse on
// each falling edge of E.
//   i_clk    system clock (CLKX4)
//   i_reset  synchronous, active-high
//   i_e      raw CPU E
//   o_e_fall one-cycle pulse after E falls
module mmu_pager_esync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_e,
    output logic o_e_fall
);
    logic r_meta, r_sync, r_prev;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_e;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_e_fall = r_prev & ~r_sync;

endmodule

// File: rtl/mmu_pager.sv
// mmu_pager: multi-task paging MMU for the 6809 board.
// Translates the CPU address through a per-task page table, applies per-page
// write protection (fault capture + IRQ) and performs a delayed task switch
// so that an RTI finishes in the old map. Vector fetches use task 0.
//   i_clkx4      system clock (4x E)
//   i_reset      synchronous, active-high
//   i_e          CPU E (asynchronous)
//   i_addr       CPU address
//   i_ba, i_bs   CPU bus status (BS=1,BA=0: vector fetch)
//   i_rnw        CPU read/not-write
//   i_data       CPU write data
//   o_data       register read data
//   o_data_oe    drive data bus (register read while E high)
//   o_paddr      translated address, registered
//   o_wr_inhibit suppress nWR for a protected write
//   o_fault      sticky write-protect fault
//   o_nirq       active-low interrupt (FAULT & IRQEN)
module mmu_pager
    import mmu_pager_pkg::*;
#(
    parameter int          PAGE_BITS    = 3,
    parameter int          TASKS        = 4,
    parameter int          PHYS_BITS    = 21,
    parameter logic [15:0] MMU_BASE     = 16'hFE20,
    parameter logic [15:0] IO_ADDR_MIN  = 16'hFC00,
    parameter logic [15:0] IO_ADDR_MAX  = 16'hFEFF,
    parameter int          SWITCH_DELAY = 3
) (
    input  logic                 i_clkx4,
    input  logic                 i_reset,
    input  logic                 i_e,
    input  logic [15:0]          i_addr,
    input  logic                 i_ba,
    input  logic                 i_bs,
    input  logic                 i_rnw,
    input  logic [7:0]           i_data,
    output logic [7:0]           o_data,
    output logic                 o_data_oe,
    output logic [PHYS_BITS-1:0] o_paddr,
    output logic                 o_wr_inhibit,
    output logic                 o_fault,
    output logic                 o_nirq
);
    localparam int TB      = $clog2(TASKS);
    localparam int PAGES   = 1 << PAGE_BITS;
    localparam int OFF_W   = 16 - PAGE_BITS;
    localparam int FRAME_W = PHYS_BITS - OFF_W;
    localparam int IW      = TB + PAGE_BITS;
    localparam int CW      = (SWITCH_DELAY > 0) ? $clog2(SWITCH_DELAY + 1) : 1;

    // page table and control state
    logic [FRAME_W-1:0] r_frame [TASKS][PAGES];
    logic               r_wp    [TASKS][PAGES];
    logic [TB-1:0]      r_cur, r_pend;
    logic [CW-1:0]      r_cnt;
    sw_state_t          r_state;
    logic [2:0]         r_ctrl;
    logic               r_fault;
    logic [IW-1:0]      r_finfo;
    logic [IW-1:0]      r_index;
    logic [PHYS_BITS-1:0] r_paddr;

    logic                 w_e_fall;
    logic [PAGE_BITS-1:0] w_page;
    logic                 w_io, w_reg_hit, w_vec, w_inhibit;
    logic [TB-1:0]        w_eff_task;
    logic [2:0]           w_off;
    logic                 w_reg_wr, w_reg_acc;
    logic [TB-1:0]        w_idx_t;
    logic [PAGE_BITS-1:0] w_idx_p;
    logic [PHYS_BITS-1:0] w_paddr_next;
    logic [7:0]           w_rd_data;
    logic                 w_pending;

    mmu_pager_esync u_esync (
        .i_clk    (i_clkx4),
        .i_reset  (i_reset),
        .i_e      (i_e),
        .o_e_fall (w_e_fall)
    );

    assign w_page     = i_addr[15 -: PAGE_BITS];
    assign w_io       = in_window(i_addr, IO_ADDR_MIN, IO_ADDR_MAX);
    assign w_reg_hit  = (i_addr[15:3] == MMU_BASE[15:3]);
    assign w_off      = i_addr[2:0];
    assign w_vec      = i_bs & ~i_ba;
    assign w_eff_task = (r_ctrl[CTRL_VEC] && w_vec) ? '0 : r_cur;
    assign w_idx_t    = r_index[IW-1:PAGE_BITS];
    assign w_idx_p    = r_index[PAGE_BITS-1:0];
    assign w_pending  = (r_state == S_COUNT);

    // register block is explicitly excluded even if a build moves it out
    // of the identity window
    assign w_inhibit = r_ctrl[CTRL_EN] & ~i_rnw & r_wp[w_eff_task][w_page]
                     & ~w_io & ~w_reg_hit;

    assign w_reg_wr  = w_e_fall & w_reg_hit & ~i_rnw;
    assign w_reg_acc = w_e_fall & w_reg_hit;

    assign w_paddr_next = (!r_ctrl[CTRL_EN] || w_io)
                        ? PHYS_BITS'(i_addr)
                        : {r_frame[w_eff_task][w_page], i_addr[OFF_W-1:0]};

    always_comb begin
        w_rd_data = '0;
        case (w_off)
            OFF_TASK:   w_rd_data = {w_pending, 3'b000, 4'(r_cur)};
            OFF_INDEX:  w_rd_data = 8'(r_index);
            OFF_FRAME:  w_rd_data = 8'(r_frame[w_idx_t][w_idx_p]);
            OFF_FLAGS:  w_rd_data = {7'b0, r_wp[w_idx_t][w_idx_p]};
            OFF_STATUS: w_rd_data = {w_pending, 6'b0, r_fault};
            OFF_CTRL:   w_rd_data = {5'b0, r_ctrl};
            OFF_FINFO:  w_rd_data = 8'(r_finfo);
            default:    w_rd_data = '0;
        endcase
    end

    always_ff @(posedge i_clkx4) begin
        if (i_reset) begin
            for (int t = 0; t < TASKS; t++) begin
                for (int p = 0; p < PAGES; p++) begin
                    r_frame[t][p] <= FRAME_W'(p);
                    r_wp[t][p]    <= 1'b0;
                end
            end
            r_cur   <= '0;
            r_pend  <= '0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_ctrl  <= '0;
            r_fault <= 1'b0;
            r_finfo <= '0;
            r_index <= '0;
            r_paddr <= '0;
        end else begin
            r_paddr <= w_paddr_next;

            if (w_e_fall) begin
                // first fault wins; later ones leave FAULTINFO alone
                if (w_inhibit && !r_fault) begin
                    r_fault <= 1'b1;
                    r_finfo <= {w_eff_task, w_page};
                end

                if (w_reg_wr) begin
                    case (w_off)
                        OFF_INDEX:  r_index <= i_data[IW-1:0];
                        OFF_FRAME:  r_frame[w_idx_t][w_idx_p] <= i_data[FRAME_W-1:0];
                        OFF_FLAGS:  r_wp[w_idx_t][w_idx_p] <= i_data[0];
                        OFF_STATUS: if (i_data[STATUS_FAULT]) r_fault <= 1'b0;
                        OFF_CTRL:   r_ctrl <= i_data[2:0];
                        default: ;
                    endcase
                end

                // FRAME/FLAGS accesses step through the table; natural wrap
                if (w_reg_acc && (w_off == OFF_FRAME || w_off == OFF_FLAGS))
                    r_index <= r_index + IW'(1);

                // task switch FSM; a vector fetch overrides everything
                if (r_ctrl[CTRL_VEC] && w_vec) begin
                    r_cur   <= '0;
                    r_state <= S_IDLE;
                end else if (w_reg_wr && w_off == OFF_TASK) begin
                    if (SWITCH_DELAY == 0) begin
                        r_cur   <= i_data[TB-1:0];
                        r_state <= S_IDLE;
                    end else begin
                        r_pend  <= i_data[TB-1:0];
                        r_cnt   <= CW'(SWITCH_DELAY);
                        r_state <= S_COUNT;
                    end
                end else if (r_state == S_COUNT) begin
                    if (r_cnt <= CW'(1)) begin
                        r_cur   <= r_pend;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
            end
        end
    end

    assign o_paddr      = r_paddr;
    assign o_data       = w_rd_data;
    assign o_data_oe    = ~i_reset & i_rnw & i_e & w_reg_hit;
    assign o_wr_inhibit = ~i_reset & w_inhibit;
    assign o_fault      = r_fault;
    assign o_nirq       = ~(r_fault & r_ctrl[CTRL_IRQEN]);

endmodule
